// File: rtl/bp_be_trap_ctrl_pkg.sv
// Shared RV64 trap definitions: cause codes, privilege modes, FSM states and
// the registered trap record.
package bp_be_trap_ctrl_pkg;

  localparam int cause_width_lp = 6;

  localparam logic [1:0] priv_u_lp = 2'd0;
  localparam logic [1:0] priv_s_lp = 2'd1;
  localparam logic [1:0] priv_m_lp = 2'd3;

  localparam logic [5:0] cause_instr_misaligned_lp   = 6'd0;
  localparam logic [5:0] cause_instr_access_fault_lp = 6'd1;
  localparam logic [5:0] cause_illegal_instr_lp      = 6'd2;
  localparam logic [5:0] cause_breakpoint_lp         = 6'd3;
  localparam logic [5:0] cause_load_misaligned_lp    = 6'd4;
  localparam logic [5:0] cause_load_access_fault_lp  = 6'd5;
  localparam logic [5:0] cause_store_misaligned_lp   = 6'd6;
  localparam logic [5:0] cause_store_access_fault_lp = 6'd7;
  localparam logic [5:0] cause_ecall_u_lp            = 6'd8;
  localparam logic [5:0] cause_ecall_s_lp            = 6'd9;
  localparam logic [5:0] cause_ecall_m_lp            = 6'd11;
  localparam logic [5:0] cause_instr_page_fault_lp   = 6'd12;
  localparam logic [5:0] cause_load_page_fault_lp    = 6'd13;
  localparam logic [5:0] cause_store_page_fault_lp   = 6'd15;

  // Bits 10 and 14 are reserved cause codes and never raise a trap
  localparam logic [63:0] rsvd_mask_lp = (64'd1 << 10) | (64'd1 << 14);

  // Standard causes, index 13 is highest priority, index 0 lowest
  localparam logic [13:0][5:0] exc_prio_order_lp = {
    cause_breakpoint_lp,         cause_instr_page_fault_lp,
    cause_instr_access_fault_lp, cause_illegal_instr_lp,
    cause_instr_misaligned_lp,   cause_ecall_u_lp,
    cause_ecall_s_lp,            cause_ecall_m_lp,
    cause_store_misaligned_lp,   cause_load_misaligned_lp,
    cause_store_page_fault_lp,   cause_load_page_fault_lp,
    cause_store_access_fault_lp, cause_load_access_fault_lp
  };

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_hold  = 2'd1,
    e_drain = 2'd2
  } trap_state_e;

  // Record is stored at full RV64 width; the top slices to vaddr_width_p
  typedef struct packed {
    logic [cause_width_lp-1:0] cause;
    logic [63:0]               epc;
    logic [63:0]               tval;
    logic [63:0]               npc;
    logic [1:0]                target_priv;
  } trap_rec_s;

  // Causes whose trap value is the faulting effective address
  function automatic logic tval_is_vaddr(input logic [cause_width_lp-1:0] c);
    case (c)
      6'd0, 6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd12, 6'd13, 6'd15: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_exc_priority_enc.sv
// Picks the single winning cause from a one-hot-or-more exception vector.
module bp_be_exc_priority_enc
  import bp_be_trap_ctrl_pkg::*;
#(
  parameter int exc_width_p = 16
) (
  input  logic [exc_width_p-1:0]    exc_i,
  output logic                      v_o,
  output logic [cause_width_lp-1:0] cause_o
);

  logic [63:0] exc_ext;
  assign exc_ext = 64'(exc_i);
  assign v_o     = |exc_i;

  // Custom causes first (lowest index wins), then standard causes overwrite
  // in rising priority so the highest-priority standard cause lands last.
  always_comb begin
    cause_o = '0;
    for (int i = 63; i >= 16; i--) begin
      if (exc_ext[i]) cause_o = 6'(i);
    end
    for (int i = 0; i < 14; i++) begin
      if (exc_ext[exc_prio_order_lp[i]]) cause_o = exc_prio_order_lp[i];
    end
  end

endmodule

// File: rtl/bp_be_trap_ctrl.sv
// Commit-stage trap controller: encodes the cause, builds a trap record,
// holds it until the consumer takes it, then drains before re-arming.
module bp_be_trap_ctrl
  import bp_be_trap_ctrl_pkg::*;
#(
  parameter int exc_width_p    = 16,
  parameter int vaddr_width_p  = 64,
  parameter int drain_cycles_p = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [exc_width_p-1:0]    exc_dec_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  vaddr_i,
  input  logic [31:0]               instr_i,
  input  logic [1:0]                priv_mode_i,
  input  logic [exc_width_p-1:0]    medeleg_i,
  input  logic [vaddr_width_p-1:0]  mtvec_i,
  input  logic [vaddr_width_p-1:0]  stvec_i,
  output logic                      trap_v_o,
  input  logic                      trap_yumi_i,
  output logic [cause_width_lp-1:0] cause_o,
  output logic [vaddr_width_p-1:0]  epc_o,
  output logic [vaddr_width_p-1:0]  tval_o,
  output logic [vaddr_width_p-1:0]  npc_o,
  output logic [1:0]                target_priv_o
);

  trap_state_e               state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  trap_rec_s                 rec_q, rec_d, new_rec;
  logic [exc_width_p-1:0]    exc_eff;
  logic                      enc_v;
  logic [cause_width_lp-1:0] enc_cause;
  logic                      accept;
  logic [63:0]               deleg_ext;
  logic                      to_s;

  assign exc_eff   = exc_dec_i & ~rsvd_mask_lp[exc_width_p-1:0];
  assign deleg_ext = 64'(medeleg_i);

  bp_be_exc_priority_enc #(.exc_width_p(exc_width_p)) u_enc (
    .exc_i   (exc_eff),
    .v_o     (enc_v),
    .cause_o (enc_cause)
  );

  assign accept = v_i & ready_o & enc_v;

  // Build the candidate trap record from the committing instruction
  always_comb begin
    new_rec       = '0;
    to_s          = (priv_mode_i != priv_m_lp) & deleg_ext[enc_cause];
    new_rec.cause = enc_cause;
    new_rec.epc   = 64'(pc_i) & ~64'd1;
    if (enc_cause == cause_illegal_instr_lp) new_rec.tval = 64'(instr_i);
    else if (tval_is_vaddr(enc_cause))       new_rec.tval = 64'(vaddr_i);
    else                                     new_rec.tval = '0;
    new_rec.target_priv = to_s ? priv_s_lp : priv_m_lp;
    new_rec.npc = (to_s ? 64'(stvec_i) : 64'(mtvec_i)) & ~64'd3;
  end

  // State, drain counter and trap record; reset clears everything
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
    end
  end

  // Next-state: capture on accept, hold until yumi, then count down the drain
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rec_d   = rec_q;
    case (state_q)
      e_idle: begin
        if (accept) begin
          state_d = e_hold;
          rec_d   = new_rec;
        end
      end
      e_hold: begin
        if (trap_yumi_i) begin
          if (drain_cycles_p == 0) begin
            state_d = e_idle;
          end else begin
            state_d = e_drain;
            cnt_d   = 4'(drain_cycles_p);
          end
        end
      end
      e_drain: begin
        if (cnt_q <= 4'd1) begin
          state_d = e_idle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = e_idle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: handshake from state, data straight from the held record
  always_comb begin
    ready_o       = (state_q == e_idle);
    trap_v_o      = (state_q == e_hold);
    cause_o       = rec_q.cause;
    epc_o         = rec_q.epc[vaddr_width_p-1:0];
    tval_o        = rec_q.tval[vaddr_width_p-1:0];
    npc_o         = rec_q.npc[vaddr_width_p-1:0];
    target_priv_o = rec_q.target_priv;
  end

endmodule
